// File: rtl/hamming_decoder.sv
`timescale 1ns/1ps
// Serial receiver for Hamming(136,128) frames: deserialises the MSB-first bit stream,
// computes the syndrome and corrects a single-bit error before presenting data in parallel.
module hamming_decoder #(
    parameter int N    = 128,
    parameter int K    = 8,
    parameter int SKIP = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sig_in,
    input  logic         din,
    output logic [N:1]   dout,
    output logic         dout_valid,
    output logic [K-1:0] syndrome,
    output logic         err_corrected,
    output logic         err_uncorrectable,
    output logic         frame_err,
    output logic         busy
);

    localparam int L  = N + K;
    localparam int CW = $clog2(L + 1);
    localparam int SW = $clog2(SKIP + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKIP,
        S_RECEIVE,
        S_SYND,
        S_CORRECT
    } state_t;

    state_t          state_q;
    logic            sig_prev_q;
    logic [CW-1:0]   bit_cnt_q;
    logic [SW-1:0]   skip_cnt_q;
    logic [L:1]      cw_q;
    logic [K-1:0]    syn_q;
    logic [N:1]      dout_q;
    logic [K-1:0]    syndrome_q;
    logic            err_corrected_q;
    logic            err_uncorrectable_q;
    logic            dout_valid_q;
    logic            frame_err_q;

    logic [K-1:0]    syn_d;
    logic [L:1]      fixed_d;
    logic [N:1]      data_d;
    logic            corr_d;
    logic            unc_d;
    logic            frame_start;

    // A frame may also start in CORRECT so that a single idle cycle between frames suffices.
    assign frame_start = sig_in && !sig_prev_q;

    always_comb begin : syndrome_calc
        syn_d = '0;
        for (int p = 1; p <= L; p++) begin
            if (cw_q[p]) syn_d = syn_d ^ K'(p);
        end
    end

    always_comb begin : correct_and_extract
        int j;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        fixed_d = '0;
        data_d  = '0;
        j       = 1;
        // A syndrome beyond L matches no position, so the word passes through unchanged.
        for (int p = 1; p <= L; p++) begin
            fixed_d[p] = cw_q[p] ^ (syn_q == K'(p));
        end
        for (int p = 1; p <= L; p++) begin
            if ((p & (p - 1)) != 0) begin
                data_d[j] = fixed_d[p];
                j++;
            end
        end
        corr_d = (syn_q != '0) && (syn_q <= K'(L));
        unc_d  = (syn_q > K'(L));
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= S_IDLE;
            // Capturing sig_in here keeps a level still high from an aborted frame from restarting.
            sig_prev_q          <= sig_in;
            bit_cnt_q           <= '0;
            skip_cnt_q          <= '0;
            cw_q                <= '0;
            syn_q               <= '0;
            dout_q              <= '0;
            syndrome_q          <= '0;
            err_corrected_q     <= 1'b0;
            err_uncorrectable_q <= 1'b0;
            dout_valid_q        <= 1'b0;
            frame_err_q         <= 1'b0;
        end else begin
            sig_prev_q   <= sig_in;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            case (state_q)
                S_IDLE: ;
                S_SKIP: begin
                    if (!sig_in) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (skip_cnt_q == SW'(SKIP - 1)) begin
                        state_q <= S_RECEIVE;
                    end else begin
                        skip_cnt_q <= skip_cnt_q + SW'(1);
                    end
                end
                S_RECEIVE: begin
                    if (!sig_in) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        cw_q      <= {cw_q[L-1:1], din};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(L - 1)) state_q <= S_SYND;
                    end
                end
                S_SYND: begin
                    syn_q   <= syn_d;
                    state_q <= S_CORRECT;
                end
                S_CORRECT: begin
                    dout_q              <= data_d;
                    syndrome_q          <= syn_q;
                    err_corrected_q     <= corr_d;
                    err_uncorrectable_q <= unc_d;
                    dout_valid_q        <= 1'b1;
                    state_q             <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // The start edge itself is the first discarded setup bit.
            if ((state_q == S_IDLE || state_q == S_CORRECT) && frame_start) begin
                bit_cnt_q  <= '0;
                skip_cnt_q <= SW'(1);
                if (SKIP == 0) begin
                    cw_q      <= {cw_q[L-1:1], din};
                    bit_cnt_q <= CW'(1);
                    state_q   <= S_RECEIVE;
                end else if (SKIP == 1) begin
                    state_q <= S_RECEIVE;
                end else begin
                    state_q <= S_SKIP;
                end
            end
        end
    end

    assign dout              = dout_q;
    assign dout_valid        = dout_valid_q;
    assign syndrome          = syndrome_q;
    assign err_corrected     = err_corrected_q;
    assign err_uncorrectable = err_uncorrectable_q;
    assign frame_err         = frame_err_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_hamming_decoder.sv
`timescale 1ns/1ps
// Directed bench for hamming_decoder: table of single/double-error frames plus hand-written
// sequences for truncation, mid-frame reset and back-to-back frames.
module tb_hamming_decoder;

    localparam logic [128:1] X = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         reset;
    logic         sig_in;
    logic         din;
    logic [128:1] dout;
    logic         dout_valid;
    logic [7:0]   syndrome;
    logic         err_corrected;
    logic         err_uncorrectable;
    logic         frame_err;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ferr_cnt = 0;

    typedef struct {
        int           cyc;
        logic [128:1] dout;
        logic [7:0]   syn;
        logic         corr;
        logic         unc;
    } rec_t;

    typedef struct {
        logic [128:1] data;
        int           flip_a;
        int           flip_b;
        int           extra;
        logic [7:0]   exp_syn;
        logic         exp_corr;
        logic         exp_unc;
        logic [128:1] exp_mask;
    } vec_t;

    rec_t rx_q[$];
    vec_t vecs[8];

    hamming_decoder dut (
        .clk              (clk),
        .reset            (reset),
        .sig_in           (sig_in),
        .din              (din),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .syndrome         (syndrome),
        .err_corrected    (err_corrected),
        .err_uncorrectable(err_uncorrectable),
        .frame_err        (frame_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_valid) rx_q.push_back('{cyc, dout, syndrome, err_corrected, err_uncorrectable});
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [136:1] encode(input logic [128:1] d);
        logic [136:1] c;
        logic [7:0]   s;
        int           j;
        c = '0;
        s = '0;
        j = 1;
        for (int p = 1; p <= 136; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[j];
                j++;
            end
        end
        for (int p = 1; p <= 136; p++) if (c[p]) s = s ^ p[7:0];
        for (int i = 0; i < 8; i++) c[1 << i] = s[i];
        return c;
    endfunction

    // Setup bit, then nbits of the codeword MSB first, optional trailing bits, then sig_in low.
    task automatic send_frame(input logic [136:1] cw, input int nbits, input int extra,
                              output int last_cyc);
        @(negedge clk);
        sig_in = 1'b1;
        din    = 1'b0;
        for (int i = 136; i > 136 - nbits; i--) begin
            @(negedge clk);
            din = cw[i];
        end
        @(negedge clk);
        last_cyc = cyc;
        for (int k = 0; k < extra; k++) begin
            din = k[0];
            @(negedge clk);
        end
        sig_in = 1'b0;
        din    = 1'b0;
    endtask

    task automatic wait_recs(input int want, input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk);
            if (rx_q.size() >= want) got = 1'b1;
        end
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [136:1] cw;
        int           lc;
        int           n;
        bit           got;
        cw = encode(v.data);
        if (v.flip_a != 0) cw[v.flip_a] = ~cw[v.flip_a];
        if (v.flip_b != 0) cw[v.flip_b] = ~cw[v.flip_b];
        n = rx_q.size();
        send_frame(cw, 136, v.extra, lc);
        wait_recs(n + 1, 12, got);
        check({tag, " dout_valid seen"}, 128'(got), 128'd1);
        if (got) begin
            check({tag, " latency"}, 128'(rx_q[n].cyc - lc), 128'd2);
            check({tag, " dout"}, rx_q[n].dout, v.data ^ v.exp_mask);
            check({tag, " syndrome"}, 128'(rx_q[n].syn), 128'(v.exp_syn));
            check({tag, " err_corrected"}, 128'(rx_q[n].corr), 128'(v.exp_corr));
            check({tag, " err_uncorrectable"}, 128'(rx_q[n].unc), 128'(v.exp_unc));
        end
        repeat (2) @(posedge clk);
        #1;
        check({tag, " busy idle"}, 128'(busy), 128'd0);
        check({tag, " single pulse"}, 128'(rx_q.size()), 128'(n + 1));
    endtask

    initial begin
        int           lc_a;
        int           lc_b;
        int           n;
        int           f;
        bit           got;
        logic [128:1] prev_dout;
        logic [7:0]   prev_syn;
        logic [136:1] cw;
        vec_t         ones_v;

        vecs[0] = '{X, 0, 0, 0, 8'd0, 1'b0, 1'b0, 128'h0};
        vecs[1] = '{X, 3, 0, 0, 8'd3, 1'b1, 1'b0, 128'h0};
        vecs[2] = '{X, 64, 0, 0, 8'd64, 1'b1, 1'b0, 128'h0};
        vecs[3] = '{X, 136, 1, 0, 8'd137, 1'b0, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000};
        vecs[4] = '{X, 136, 0, 3, 8'd136, 1'b1, 1'b0, 128'h0};
        vecs[5] = '{X, 1, 0, 0, 8'd1, 1'b1, 1'b0, 128'h0};
        vecs[6] = '{128'h0, 129, 130, 0, 8'd3, 1'b1, 1'b0, 128'h0300_0000_0000_0000_0000_0000_0000_0001};
        vecs[7] = '{X, 128, 0, 0, 8'd128, 1'b1, 1'b0, 128'h0};

        reset  = 1'b1;
        sig_in = 1'b0;
        din    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dout", dout, 128'h0);
        check("reset syndrome", 128'(syndrome), 128'd0);
        check("reset flags", 128'({dout_valid, err_corrected, err_uncorrectable, frame_err, busy}), 128'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Truncated frame: outputs keep the last decoded values.
        prev_dout = dout;
        prev_syn  = syndrome;
        n = rx_q.size();
        f = ferr_cnt;
        send_frame(encode(X), 50, 0, lc_a);
        repeat (4) @(posedge clk);
        #1;
        check("trunc frame_err pulses", 128'(ferr_cnt - f), 128'd1);
        check("trunc no dout_valid", 128'(rx_q.size()), 128'(n));
        check("trunc busy idle", 128'(busy), 128'd0);
        check("trunc dout held", dout, prev_dout);
        check("trunc syndrome held", 128'(syndrome), 128'(prev_syn));
        run_vec(vecs[1], "after trunc");

        // Reset mid-frame with sig_in still high afterwards.
        n  = rx_q.size();
        f  = ferr_cnt;
        cw = encode(X);
        @(negedge clk);
        sig_in = 1'b1;
        din    = 1'b0;
        for (int i = 136; i > 66; i--) begin
            @(negedge clk);
            din = cw[i];
        end
        @(negedge clk);
        check("busy mid-frame", 128'(busy), 128'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        sig_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset abort no frame_err", 128'(ferr_cnt - f), 128'd0);
        check("reset abort no dout_valid", 128'(rx_q.size()), 128'(n));
        check("reset abort busy", 128'(busy), 128'd0);
        check("reset abort dout cleared", dout, 128'h0);
        ones_v = '{{128{1'b1}}, 0, 0, 0, 8'd0, 1'b0, 1'b0, 128'h0};
        run_vec(ones_v, "all ones");

        // Back-to-back frames separated by one low cycle.
        n  = rx_q.size();
        cw = encode(128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0);
        cw[77] = ~cw[77];
        send_frame(encode(X), 136, 0, lc_a);
        send_frame(cw, 136, 0, lc_b);
        wait_recs(n + 2, 20, got);
        check("b2b two pulses", 128'(got), 128'd1);
        if (got) begin
            check("b2b A latency", 128'(rx_q[n].cyc - lc_a), 128'd2);
            check("b2b A dout", rx_q[n].dout, X);
            check("b2b A syndrome", 128'(rx_q[n].syn), 128'd0);
            check("b2b B latency", 128'(rx_q[n+1].cyc - lc_b), 128'd2);
            check("b2b B dout", rx_q[n+1].dout, 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0);
            check("b2b B syndrome", 128'(rx_q[n+1].syn), 128'd77);
            check("b2b B corrected", 128'(rx_q[n+1].corr), 128'd1);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
